rvh_l1d_lst_wr_sched: RTL and testbench

Write scheduler for the L1D line state table (LST) MESI array. Arbitrates MESI-state writes from three requesters (snoop, MLFB refill, pipeline s0) onto a single registered LST write port. Refill writes are buffered in a small FIFO. Ordering hazards between requesters on the same set/way are resolved by stalling the younger requester. Sits between the bank pipeline/snoop/MLFB control and the LST write inputs.

---
 rtl/rvh_l1d_lst_wr_sched.sv | 181 ++++++++++++++++++
 tb/tb_rvh_l1d_lst_wr_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_lst_wr_sched.sv
// LST MESI write scheduler: snoop/refill-FIFO/pipe arbitration onto one registered write port; 1-cycle grant-to-write latency.
// Hazarded requesters are stalled via rdy; refill FIFO backpressures when full. Optional starvation promotion: RVH_L1D_LST_SCHED_STARVE_EN.
module rvh_l1d_lst_wr_sched #(
    parameter int SET_IDX_W    = 5,
    parameter int WAY_IDX_W    = 2,
    parameter int MESI_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         snp_vld,
    output logic                         snp_rdy,
    input  logic [SET_IDX_W-1:0]         snp_set_idx,
    input  logic [WAY_IDX_W-1:0]         snp_way_idx,
    input  logic [MESI_W-1:0]            snp_dat,
    input  logic                         mlfb_vld,
    output logic                         mlfb_rdy,
    input  logic [SET_IDX_W-1:0]         mlfb_set_idx,
    input  logic [WAY_IDX_W-1:0]         mlfb_way_idx,
    input  logic [MESI_W-1:0]            mlfb_dat,
    input  logic                         pipe_vld,
    output logic                         pipe_rdy,
    input  logic [SET_IDX_W-1:0]         pipe_set_idx,
    input  logic [WAY_IDX_W-1:0]         pipe_way_idx,
    input  logic [MESI_W-1:0]            pipe_dat,
    output logic                         lst_wr_en,
    output logic [SET_IDX_W-1:0]         lst_wr_set_idx,
    output logic [WAY_IDX_W-1:0]         lst_wr_way_idx,
    output logic [MESI_W-1:0]            lst_wr_dat,
    output logic [1:0]                   lst_wr_src,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
    output logic                         busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_SNP  = 2'd1;
    localparam logic [1:0] SRC_MLFB = 2'd2;
    localparam logic [1:0] SRC_PIPE = 2'd3;

    logic [SET_IDX_W-1:0] fifo_set_q [FIFO_DEPTH];
    logic [WAY_IDX_W-1:0] fifo_way_q [FIFO_DEPTH];
    logic [MESI_W-1:0]    fifo_dat_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0] snp_match, pipe_match;

    logic fifo_ne, fifo_push, fifo_gnt, snp_gnt, pipe_gnt, starve_prom;

    logic                 wr_en_q, wr_en_d;
    logic [SET_IDX_W-1:0] wr_set_q, wr_set_d;
    logic [WAY_IDX_W-1:0] wr_way_q, wr_way_d;
    logic [MESI_W-1:0]    wr_dat_q, wr_dat_d;
    logic [1:0]           wr_src_q, wr_src_d;

    // An entry is live when its distance from the read pointer is below the occupancy.
    genvar g;
    generate
        for (g = 0; g < FIFO_DEPTH; g++) begin : g_ent
            logic [PTR_W-1:0] off;
            logic             live;
            assign off  = PTR_W'(g) - rd_ptr_q;
            assign live = {1'b0, off} < cnt_q;
            assign snp_match[g]  = live && (fifo_set_q[g] == snp_set_idx)
                                        && (fifo_way_q[g] == snp_way_idx);
            assign pipe_match[g] = live && (fifo_set_q[g] == pipe_set_idx)
                                        && (fifo_way_q[g] == pipe_way_idx);
        end
    endgenerate

    assign fifo_ne   = (cnt_q != '0);
    assign mlfb_rdy  = (cnt_q < CNT_W'(FIFO_DEPTH));
    assign fifo_push = mlfb_vld && mlfb_rdy;

    // A hazarded or promoted FIFO wins; otherwise snoop > FIFO head > pipe.
    assign snp_rdy  = !(|snp_match) && !starve_prom;
    assign snp_gnt  = snp_vld && snp_rdy;
    assign fifo_gnt = fifo_ne && !snp_gnt;
    assign pipe_rdy = !(|pipe_match) && !fifo_ne && !snp_gnt;
    assign pipe_gnt = pipe_vld && pipe_rdy;

`ifdef RVH_L1D_LST_SCHED_STARVE_EN
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    logic [STV_W-1:0] starve_q, starve_d;

    assign starve_prom = (starve_q == STV_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!fifo_ne || fifo_gnt) begin
            starve_d = '0;
        end else if (!starve_prom) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_prom = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(fifo_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(fifo_gnt);
        cnt_d    = cnt_q;
        if (fifo_push && !fifo_gnt) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!fifo_push && fifo_gnt) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        wr_en_d  = snp_gnt || fifo_gnt || pipe_gnt;
        wr_set_d = wr_set_q;
        wr_way_d = wr_way_q;
        wr_dat_d = wr_dat_q;
        wr_src_d = SRC_NONE;
        if (snp_gnt) begin
            wr_set_d = snp_set_idx;
            wr_way_d = snp_way_idx;
            wr_dat_d = snp_dat;
            wr_src_d = SRC_SNP;
        end else if (fifo_gnt) begin
            wr_set_d = fifo_set_q[rd_ptr_q];
            wr_way_d = fifo_way_q[rd_ptr_q];
            wr_dat_d = fifo_dat_q[rd_ptr_q];
            wr_src_d = SRC_MLFB;
        end else if (pipe_gnt) begin
            wr_set_d = pipe_set_idx;
            wr_way_d = pipe_way_idx;
            wr_dat_d = pipe_dat;
            wr_src_d = SRC_PIPE;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_set_q[wr_ptr_q] <= mlfb_set_idx;
            fifo_way_q[wr_ptr_q] <= mlfb_way_idx;
            fifo_dat_q[wr_ptr_q] <= mlfb_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_set_q <= '0;
            wr_way_q <= '0;
            wr_dat_q <= '0;
            wr_src_q <= SRC_NONE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            wr_set_q <= wr_set_d;
            wr_way_q <= wr_way_d;
            wr_dat_q <= wr_dat_d;
            wr_src_q <= wr_src_d;
        end
    end

    assign lst_wr_en      = wr_en_q;
    assign lst_wr_set_idx = wr_set_q;
    assign lst_wr_way_idx = wr_way_q;
    assign lst_wr_dat     = wr_dat_q;
    assign lst_wr_src     = wr_src_q;
    assign fifo_cnt       = cnt_q;
    assign busy           = fifo_ne || wr_en_q;
endmodule

// File: tb/tb_rvh_l1d_lst_wr_sched.sv
// Bench for rvh_l1d_lst_wr_sched: directed table, corner sequences and random traffic against a queue-based model.
module tb_rvh_l1d_lst_wr_sched;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef RVH_L1D_LST_SCHED_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       snp_vld, snp_rdy, mlfb_vld, mlfb_rdy, pipe_vld, pipe_rdy;
    logic [4:0] snp_set_idx, mlfb_set_idx, pipe_set_idx, lst_wr_set_idx;
    logic [1:0] snp_way_idx, mlfb_way_idx, pipe_way_idx, lst_wr_way_idx;
    logic [1:0] snp_dat, mlfb_dat, pipe_dat, lst_wr_dat, lst_wr_src;
    logic       lst_wr_en, busy;
    logic [2:0] fifo_cnt;

    rvh_l1d_lst_wr_sched dut (
        .clk(clk), .rst(rst),
        .snp_vld(snp_vld), .snp_rdy(snp_rdy), .snp_set_idx(snp_set_idx),
        .snp_way_idx(snp_way_idx), .snp_dat(snp_dat),
        .mlfb_vld(mlfb_vld), .mlfb_rdy(mlfb_rdy), .mlfb_set_idx(mlfb_set_idx),
        .mlfb_way_idx(mlfb_way_idx), .mlfb_dat(mlfb_dat),
        .pipe_vld(pipe_vld), .pipe_rdy(pipe_rdy), .pipe_set_idx(pipe_set_idx),
        .pipe_way_idx(pipe_way_idx), .pipe_dat(pipe_dat),
        .lst_wr_en(lst_wr_en), .lst_wr_set_idx(lst_wr_set_idx),
        .lst_wr_way_idx(lst_wr_way_idx), .lst_wr_dat(lst_wr_dat),
        .lst_wr_src(lst_wr_src), .fifo_cnt(fifo_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pending refills as a queue, plus expected output register.
    typedef struct { int s; int w; int d; } ent_t;
    ent_t mq[$];
    int   m_starve;
    bit   exp_en;
    int   exp_set, exp_way, exp_dat, exp_src;
    bit   m_snp_ok, m_snp_go, m_fifo_go, m_pipe_ok, m_pipe_go;

    typedef struct {
        int pre, pset, pway, pdat;
        int sv, ss, sw, sd;
        int mv, ms, mw, md;
        int pv, ps, pw, pd;
        int esnp, epipe, emlfb;
        int esrc, eset, eway, edat;
    } vec_t;
    vec_t vt[8];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit pending(int s, int w);
        foreach (mq[i]) if (mq[i].s == s && mq[i].w == w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic decide();
        bit prom;
        prom      = STARVE_ON && (m_starve >= LIMIT);
        m_snp_ok  = !pending(int'(snp_set_idx), int'(snp_way_idx)) && !prom;
        m_snp_go  = snp_vld && m_snp_ok;
        m_fifo_go = !m_snp_go && (mq.size() > 0);
        m_pipe_ok = !m_snp_go && (mq.size() == 0)
                    && !pending(int'(pipe_set_idx), int'(pipe_way_idx));
        m_pipe_go = pipe_vld && m_pipe_ok;
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        exp_en   = 1'b0;
        exp_src  = 0;
        exp_set  = 0;
        exp_way  = 0;
        exp_dat  = 0;
    endtask

    task automatic model_step();
        int  sz;
        bit  was_empty;
        sz        = mq.size();
        was_empty = (sz == 0);
        exp_en    = m_snp_go || m_fifo_go || m_pipe_go;
        exp_src   = 0;
        if (m_snp_go) begin
            exp_set = snp_set_idx; exp_way = snp_way_idx; exp_dat = snp_dat; exp_src = 1;
        end else if (m_fifo_go) begin
            exp_set = mq[0].s; exp_way = mq[0].w; exp_dat = mq[0].d; exp_src = 2;
        end else if (m_pipe_go) begin
            exp_set = pipe_set_idx; exp_way = pipe_way_idx; exp_dat = pipe_dat; exp_src = 3;
        end
        if (m_fifo_go) void'(mq.pop_front());
        if (mlfb_vld && sz < DEPTH)
            mq.push_back('{int'(mlfb_set_idx), int'(mlfb_way_idx), int'(mlfb_dat)});
        if (was_empty || m_fifo_go) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
    endtask

    task automatic sample();
        @(negedge clk);
        decide();
        chk("snp_rdy", snp_rdy, m_snp_ok);
        chk("pipe_rdy", pipe_rdy, m_pipe_ok);
        chk("mlfb_rdy", mlfb_rdy, mq.size() < DEPTH);
        chk("fifo_cnt", fifo_cnt, mq.size());
        chk("busy", busy, (mq.size() > 0) || exp_en);
        chk("lst_wr_en", lst_wr_en, exp_en);
        chk("lst_wr_src", lst_wr_src, exp_src);
        if (exp_en) begin
            chk("lst_wr_set", lst_wr_set_idx, exp_set);
            chk("lst_wr_way", lst_wr_way_idx, exp_way);
            chk("lst_wr_dat", lst_wr_dat, exp_dat);
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        snp_vld = 0;  snp_set_idx = 5'd31;  snp_way_idx = 2'd3;  snp_dat = 0;
        mlfb_vld = 0; mlfb_set_idx = 5'd31; mlfb_way_idx = 2'd3; mlfb_dat = 0;
        pipe_vld = 0; pipe_set_idx = 5'd31; pipe_way_idx = 2'd3; pipe_dat = 0;
    endtask

    task automatic set_snp(logic v, int s, int w, int d);
        snp_vld = v; snp_set_idx = 5'(s); snp_way_idx = 2'(w); snp_dat = 2'(d);
    endtask
    task automatic set_mlfb(logic v, int s, int w, int d);
        mlfb_vld = v; mlfb_set_idx = 5'(s); mlfb_way_idx = 2'(w); mlfb_dat = 2'(d);
    endtask
    task automatic set_pipe(logic v, int s, int w, int d);
        pipe_vld = v; pipe_set_idx = 5'(s); pipe_way_idx = 2'(w); pipe_dat = 2'(d);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Holds snoop on an unrelated line while pushing four refills to sets 1..4.
    task automatic fill_four();
        for (int i = 0; i < 4; i++) begin
            set_snp(1, 20, 0, 1);
            set_mlfb(1, i + 1, i % 4, (i % 3) + 1);
            sample();
            advance();
        end
    endtask

    initial begin
        int k;
        set_idle();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_lst_wr_en", lst_wr_en, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_mlfb_rdy", mlfb_rdy, 1);
        chk("rst_snp_rdy", snp_rdy, 1);
        chk("rst_pipe_rdy", pipe_rdy, 1);
        do_reset();
        sample();
        advance();

        //          pre set way dat | snp v s w d | mlfb v s w d | pipe v s w d | rdy s p m | src set way dat
        vt[0] = '{0, 0, 0, 0,  0, 31, 3, 0,  0, 31, 3, 0,  1, 3, 1, 2,   1, 1, 1,  3, 3, 1, 2};
        vt[1] = '{0, 0, 0, 0,  1, 4, 0, 1,   0, 31, 3, 0,  1, 9, 3, 2,   1, 0, 1,  1, 4, 0, 1};
        vt[2] = '{1, 7, 2, 3,  1, 7, 2, 1,   0, 31, 3, 0,  0, 31, 3, 0,  0, 0, 1,  2, 7, 2, 3};
        vt[3] = '{1, 7, 2, 3,  1, 8, 2, 1,   0, 31, 3, 0,  0, 31, 3, 0,  1, 0, 1,  1, 8, 2, 1};
        vt[4] = '{1, 5, 0, 3,  0, 31, 3, 0,  0, 31, 3, 0,  1, 5, 0, 1,   1, 0, 1,  2, 5, 0, 3};
        vt[5] = '{1, 5, 0, 2,  0, 31, 3, 0,  0, 31, 3, 0,  1, 5, 1, 1,   1, 0, 1,  2, 5, 0, 2};
        vt[6] = '{0, 0, 0, 0,  0, 31, 3, 0,  0, 31, 3, 0,  0, 31, 3, 0,  1, 1, 1,  0, 0, 0, 0};
        vt[7] = '{0, 0, 0, 0,  0, 31, 3, 0,  1, 2, 2, 3,   0, 31, 3, 0,  1, 1, 1,  0, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vt[i].pre != 0) begin
                set_mlfb(1, vt[i].pset, vt[i].pway, vt[i].pdat);
                sample();
                advance();
                set_idle();
            end
            set_snp(vt[i].sv[0], vt[i].ss, vt[i].sw, vt[i].sd);
            set_mlfb(vt[i].mv[0], vt[i].ms, vt[i].mw, vt[i].md);
            set_pipe(vt[i].pv[0], vt[i].ps, vt[i].pw, vt[i].pd);
            sample();
            chk($sformatf("vec%0d_snp_rdy", i), snp_rdy, vt[i].esnp);
            chk($sformatf("vec%0d_pipe_rdy", i), pipe_rdy, vt[i].epipe);
            chk($sformatf("vec%0d_mlfb_rdy", i), mlfb_rdy, vt[i].emlfb);
            advance();
            set_idle();
            sample();
            chk($sformatf("vec%0d_src", i), lst_wr_src, vt[i].esrc);
            chk($sformatf("vec%0d_en", i), lst_wr_en, vt[i].esrc != 0);
            if (vt[i].esrc != 0) begin
                chk($sformatf("vec%0d_set", i), lst_wr_set_idx, vt[i].eset);
                chk($sformatf("vec%0d_way", i), lst_wr_way_idx, vt[i].eway);
                chk($sformatf("vec%0d_dat", i), lst_wr_dat, vt[i].edat);
            end
            advance();
        end

        // Refill pending on 7/2 orders ahead of a snoop to the same line.
        do_reset();
        set_mlfb(1, 7, 2, 3); sample(); advance(); set_idle();
        set_snp(1, 7, 2, 1);  sample(); chk("order_snp_held", snp_rdy, 0); advance();
        sample(); chk("order_snp_rdy", snp_rdy, 1); chk("order_refill_src", lst_wr_src, 2); advance();
        set_idle(); sample(); chk("order_snp_src", lst_wr_src, 1); chk("order_snp_dat", lst_wr_dat, 1); advance();

        // Simultaneous snoop/refill/pipe to one line on an empty FIFO.
        do_reset();
        set_snp(1, 10, 1, 1); set_mlfb(1, 10, 1, 3); set_pipe(1, 10, 1, 2);
        sample(); chk("sim_snp_rdy", snp_rdy, 1); chk("sim_pipe_rdy0", pipe_rdy, 0); advance();
        set_snp(0, 31, 3, 0); set_mlfb(0, 31, 3, 0);
        sample(); chk("sim_pipe_held", pipe_rdy, 0); chk("sim_src_snp", lst_wr_src, 1); advance();
        sample(); chk("sim_pipe_rdy1", pipe_rdy, 1); chk("sim_src_refill", lst_wr_src, 2); advance();
        set_idle(); sample(); chk("sim_src_pipe", lst_wr_src, 3); advance();

        // Full FIFO: no fifth push, then drain in push order with no push-through.
        do_reset();
        fill_four();
        set_mlfb(1, 9, 1, 2);
        sample(); chk("full_cnt", fifo_cnt, 4); chk("full_mlfb_rdy", mlfb_rdy, 0); advance();
        set_snp(0, 31, 3, 0); set_pipe(1, 25, 3, 1);
        sample(); chk("full_no_pushthru", mlfb_rdy, 0); advance();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("drain%0d_src", i), lst_wr_src, 2);
            chk($sformatf("drain%0d_set", i), lst_wr_set_idx, i + 1);
            advance();
            set_mlfb(0, 31, 3, 0);
        end
        for (int i = 0; i < 4; i++) begin sample(); advance(); end
        set_idle();

        // Starvation: one refill behind a continuous unrelated snoop.
        do_reset();
        set_snp(1, 20, 0, 1); set_mlfb(1, 1, 1, 2);
        sample(); advance();
        set_mlfb(0, 31, 3, 0);
        k = 0;
        while (k < 20) begin
            sample();
            if (snp_rdy !== 1'b1) break;
            k++;
            advance();
        end
        chk("starve_cycles", k, STARVE_ON ? LIMIT : 20);
        if (k < 20) begin
            advance();
            sample(); chk("starve_src", lst_wr_src, 2);
        end else begin
            chk("starve_fifo_kept", fifo_cnt, 1);
        end
        advance();
        set_idle();

        // Reset with three queued refills and a write on the port.
        do_reset();
        fill_four();
        set_idle();
        sample(); advance();
        sample(); chk("pre_rst_en", lst_wr_en, 1); chk("pre_rst_cnt", fifo_cnt, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_en", lst_wr_en, 0); chk("arst_src", lst_wr_src, 0);
        chk("arst_set", lst_wr_set_idx, 0); chk("arst_dat", lst_wr_dat, 0);
        chk("arst_cnt", fifo_cnt, 0); chk("arst_busy", busy, 0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end

        // Random traffic on a small line space to provoke hazards.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_snp($urandom_range(0, 99) < 45, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
            set_mlfb($urandom_range(0, 99) < 50, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
            set_pipe($urandom_range(0, 99) < 50, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
